// File: rtl/lc3_mon_pkg.sv
// Shared definitions for the LC-3 bus monitor: opcodes, check IDs and
// opcode classification helpers.
package lc3_mon_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_type;

    localparam int NUM_CHECKS         = 6;

    localparam int CHK_RESET_VAL      = 0;
    localparam int CHK_FLAGS_MULTI    = 1;
    localparam int CHK_FLAGS_UNEXP    = 2;
    localparam int CHK_WE_NONSTORE    = 3;
    localparam int CHK_WE_LONG        = 4;
    localparam int CHK_BUS_CONTENTION = 5;

    // Instructions that legitimately update the condition codes.
    function automatic logic is_flag_setter(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
               (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    // Instructions that legitimately assert the memory write enable.
    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/lc3_mon_satcnt.sv
// Saturating event counter with synchronous clear; one per monitor check.
module lc3_mon_satcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count events, stick at all-ones, and let clear take priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/lc3_bus_monitor.sv
// Run-time protocol monitor for the LC-3 datapath. Observes control and
// status nets, records sticky errors, per-check counts and the first
// error, and pulses an interrupt when any check fires.
module lc3_bus_monitor
    import lc3_mon_pkg::*;
#(
    parameter int N_DRIVERS     = 4,
    parameter int MAX_WE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        check_en,
    input  logic [NUM_CHECKS-1:0]       err_mask,
    input  logic                        clear,
    input  logic                        n_flag,
    input  logic                        z_flag,
    input  logic                        p_flag,
    input  logic                        memwe,
    input  logic [N_DRIVERS-1:0]        bus_en,
    input  logic [3:0]                  opcode,
    input  logic [15:0]                 pc,
    input  logic [15:0]                 ir,
    input  logic [15:0]                 mdr,
    input  logic [15:0]                 mar,
    output logic [NUM_CHECKS-1:0]       err_sticky,
    output logic [NUM_CHECKS*CNT_W-1:0] err_count,
    output logic                        first_err_valid,
    output logic [2:0]                  first_err_id,
    output logic [15:0]                 first_err_pc,
    output logic                        err_irq
);

    localparam logic [3:0] WE_LIMIT = 4'(MAX_WE_CYCLES);

    logic                  post_rst;
    logic [3:0]            opcode_q;
    logic [2:0]            flags_q;
    logic [3:0]            we_run;
    logic [2:0]            flags;
    logic [N_DRIVERS-1:0]  bus_low_cleared;
    logic [NUM_CHECKS-1:0] raw;
    logic [NUM_CHECKS-1:0] fire;
    logic [2:0]            first_id_next;

    assign flags           = {n_flag, z_flag, p_flag};
    assign bus_low_cleared = bus_en & (bus_en - N_DRIVERS'(1));
    assign fire            = raw & {NUM_CHECKS{check_en}} & ~err_mask;

    // Evaluate every protocol check from the current sample and history.
    always_comb begin
        raw = '0;
        raw[CHK_RESET_VAL]      = post_rst &
                                  ((|pc) | (|ir) | (|mdr) | (|mar) | (|flags));
        raw[CHK_FLAGS_MULTI]    = (n_flag & z_flag) | (n_flag & p_flag) |
                                  (z_flag & p_flag);
        raw[CHK_FLAGS_UNEXP]    = ~post_rst & ~is_flag_setter(opcode_q) &
                                  (flags != flags_q);
        raw[CHK_WE_NONSTORE]    = memwe & ~is_store(opcode);
        raw[CHK_WE_LONG]        = memwe & (we_run >= WE_LIMIT);
        raw[CHK_BUS_CONTENTION] = |bus_low_cleared;
    end

    // Pick the lowest-numbered check that fired this cycle.
    always_comb begin
        first_id_next = '0;
        for (int k = NUM_CHECKS - 1; k >= 0; k--) begin
            if (fire[k]) begin
                first_id_next = 3'(k);
            end
        end
    end

    // History registers: previous opcode/flags, memwe run length, and the
    // one-shot marker for the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            post_rst <= 1'b1;
            opcode_q <= '0;
            flags_q  <= '0;
            we_run   <= '0;
        end else begin
            post_rst <= 1'b0;
            opcode_q <= opcode;
            flags_q  <= flags;
            if (!memwe) begin
                we_run <= '0;
            end else if (we_run != 4'hF) begin
                we_run <= we_run + 4'd1;
            end
        end
    end

    // Sticky bits, first-error capture and interrupt pulse; clear discards
    // anything that fires in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky      <= '0;
            first_err_valid <= 1'b0;
            first_err_id    <= '0;
            first_err_pc    <= '0;
            err_irq         <= 1'b0;
        end else if (clear) begin
            err_sticky      <= '0;
            first_err_valid <= 1'b0;
            first_err_id    <= '0;
            first_err_pc    <= '0;
            err_irq         <= 1'b0;
        end else begin
            err_sticky <= err_sticky | fire;
            err_irq    <= |fire;
            if (!first_err_valid && (|fire)) begin
                first_err_valid <= 1'b1;
                first_err_id    <= first_id_next;
                first_err_pc    <= pc;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CHECKS; k++) begin : g_cnt
            lc3_mon_satcnt #(
                .W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (clear),
                .inc   (fire[k]),
                .cnt   (err_count[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: doc/lc3_bus_monitor.md
Name: lc3_bus_monitor

Overview:
- Synthesizable run-time protocol monitor for the LC-3 datapath. It is the parametrised hardware successor to the simulation-only LC-3 assertion checkers.
- Samples the same control and status nets on every clock: flags, memwe, bus-driver enables, opcode, and the pc/ir/mdr/mar values.
- Flags violations as sticky bits with per-check saturating counters, and captures the first error (check ID and pc).
- Raises an interrupt pulse so firmware or the FPGA debug core can react. Sits beside the LC-3 core and only observes; it never drives the core.

Parameters:
- N_DRIVERS, 4, number of tri-state bus-driver enables checked for contention (min 2).
- MAX_WE_CYCLES, 1, maximum legal consecutive cycles memwe may stay high (1..15).
- CNT_W, 8, width of each per-check saturating error counter.
- NUM_CHECKS, 6, number of checks (fixed by the package; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- check_en  in  1  global enable; when 0, no check fires.
- err_mask  in  NUM_CHECKS  1 = suppress that check (no sticky, count or irq).
- clear  in  1  synchronous clear of sticky bits, counters and first-error capture.
- n_flag, z_flag, p_flag  in  1 each  condition codes.
- memwe  in  1  memory write enable.
- bus_en  in  N_DRIVERS  bus-driver enables {en_alu, en_mdr, en_marmux, en_pc} at default.
- opcode  in  4  current instruction opcode.
- pc, ir, mdr, mar  in  16 each  core registers.
- err_sticky  out  NUM_CHECKS  sticky per-check error bits.
- err_count  out  NUM_CHECKS*CNT_W  packed counters; check k occupies bits [k*CNT_W +: CNT_W].
- first_err_valid  out  1  a first error has been captured.
- first_err_id  out  3  ID of the first error.
- first_err_pc  out  16  pc sampled with the first error.
- err_irq  out  1  one-cycle pulse on any newly fired check.

Behaviour:
- Reset (async, active-high): all outputs 0, all internal history 0, post_rst flag set.
- Check IDs:
  - 0 RESET_VAL: fires on the first edge with reset low (post_rst=1) if any of pc, ir, mdr, mar, n, z or p is nonzero. post_rst clears after that edge.
  - 1 FLAGS_MULTI: fires when more than one of n/z/p is high.
  - 2 FLAGS_UNEXP: fires when opcode_q (registered previous opcode) is not ADD, AND, NOT, LD, LDR or LDI, and {n,z,p} != {n,z,p}_q. Suppressed while post_rst=1.
  - 3 WE_NONSTORE: fires when memwe=1 and opcode is not ST, STR or STI.
  - 4 WE_LONG: run counter we_run (4 bits, saturating at 15) increments while memwe=1 and is zeroed when memwe=0. Fires on every edge where memwe=1 and the pre-increment we_run >= MAX_WE_CYCLES, i.e. on the (MAX_WE_CYCLES+1)-th consecutive high cycle and onward.
  - 5 BUS_CONTENTION: fires when more than one bus_en bit is high.
- Firing: fire[k] = raw[k] & check_en & ~err_mask[k].
- Latency: conditions are sampled at edge t and outputs are registered, so they are visible after edge t (one cycle).
- Sticky bits: err_sticky[k] sets on fire[k] and holds until clear.
- Counters: err_count[k] increments on fire[k] and saturates at all-ones (no wrap).
- First-error capture: on the first cycle where any fire is set and first_err_valid=0, latch first_err_id = lowest fired ID and first_err_pc = pc, then set valid. Later errors do not overwrite the capture.
- err_irq = 1 for one cycle after any edge where fire != 0, regardless of sticky state.
- Clear: clear=1 zeroes err_sticky, err_count and first_err_*. Errors firing in the same cycle are discarded (clear wins). History regs (opcode_q, flags_q, we_run) are unaffected.
- Reset mid-run: all state is lost immediately (async) and post_rst re-arms.
- History regs opcode_q and flags_q update every cycle.

Decomposition:
- Package lc3_mon_pkg holds:
  - the opcode_type enum (moved out of global scope);
  - check ID localparams CHK_RESET_VAL .. CHK_BUS_CONTENTION;
  - NUM_CHECKS = 6;
  - functions is_flag_setter(opcode) and is_store(opcode).
- Sub-module lc3_mon_satcnt (parameter W; inputs clk, reset, clr, inc; output cnt) is instantiated once per check via a generate loop.

Test Plan:
- Release reset with pc=16'h3000 on the first low edge → err_sticky[0]=1, first_err_id=0, first_err_pc=16'h3000, err_irq pulses once.
- n=1, p=1 for 3 cycles, opcode=ADD → err_count[1]=3, sticky[1]=1.
- opcode=BR, then z toggles 0→1 on the next edge → sticky[2]=1. Repeat with opcode=ADD → no fire.
- MAX_WE_CYCLES=1, opcode=ST, memwe high for 3 cycles → err_count[4]=2, sticky[3]=0.
- bus_en=4'b0101 for 300 cycles with CNT_W=8 → err_count[5]=255 (saturated), then clear → all outputs 0 one cycle later.
- err_mask[5]=1, bus_en=4'b1100 → no sticky, no irq. Then check_en=0 with opcode=ADD and memwe=1 → no fires.
